// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt arbitration, flush and CP0 update.
// Optional WB->CP0 forwarding is enabled by defining EXC_CP0_BYPASS_EN.
module exc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] excepttype_o,
    output logic        exc_we_o,
    output logic        exc_epc_we_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] exc_epc_o,
    output logic        exc_bd_o,
    output logic        eret_o,
    output logic [15:0] exc_count_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state;
    logic [31:0] status_e;
    logic [31:0] cause_e;
    logic [31:0] epc_e;
    logic        int_pend;
    logic        take;
    logic        sel_any;
    logic        sel_eret;
    logic [31:0] sel_type;
    logic [4:0]  sel_code;
    logic [31:0] epc_val;

`ifdef EXC_CP0_BYPASS_EN
    // Effective CP0 view with the same-cycle WB write forwarded
    always_comb begin
        status_e = cp0_status_i;
        cause_e  = cp0_cause_i;
        epc_e    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                5'd12: status_e = wb_cp0_data_i;
                5'd13: begin
                    cause_e[9:8] = wb_cp0_data_i[9:8];
                    cause_e[22]  = wb_cp0_data_i[22];
                    cause_e[23]  = wb_cp0_data_i[23];
                end
                5'd14: epc_e = wb_cp0_data_i;
                default: ;
            endcase
        end
    end

    wire unused_in = &{1'b0, excepttype_i[31:13], excepttype_i[7:0]};
`else
    assign status_e = cp0_status_i;
    assign cause_e  = cp0_cause_i;
    assign epc_e    = cp0_epc_i;

    wire unused_in = &{1'b0, excepttype_i[31:13], excepttype_i[7:0],
                       wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i};
`endif

    wire unused_cp0 = &{1'b0, status_e[31:16], status_e[7:2],
                        cause_e[31:16], cause_e[7:0]};

    assign int_pend = (|(cause_e[15:8] & status_e[15:8]))
                    & ~status_e[1] & status_e[0];

    // Pick the highest-priority pending event
    always_comb begin
        sel_any  = 1'b1;
        sel_eret = 1'b0;
        sel_type = 32'd0;
        sel_code = 5'd0;
        priority case (1'b1)
            int_pend:         begin sel_type = 32'h1; sel_code = 5'd0;  end
            excepttype_i[8]:  begin sel_type = 32'h8; sel_code = 5'd8;  end
            excepttype_i[9]:  begin sel_type = 32'ha; sel_code = 5'd10; end
            excepttype_i[10]: begin sel_type = 32'hd; sel_code = 5'd13; end
            excepttype_i[11]: begin sel_type = 32'hc; sel_code = 5'd12; end
            excepttype_i[12]: begin sel_type = 32'he; sel_eret = 1'b1;  end
            default:          sel_any = 1'b0;
        endcase
    end

    assign take    = (state == IDLE) & ~stall_i
                   & (inst_addr_i != 32'd0) & sel_any;
    assign epc_val = in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i;

    // FSM: register the selected event for one flush cycle and count it
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            flush_o      <= 1'b0;
            new_pc_o     <= 32'd0;
            excepttype_o <= 32'd0;
            exc_we_o     <= 1'b0;
            exc_epc_we_o <= 1'b0;
            exc_code_o   <= 5'd0;
            exc_epc_o    <= 32'd0;
            exc_bd_o     <= 1'b0;
            eret_o       <= 1'b0;
            exc_count_o  <= 16'd0;
        end else begin
            flush_o      <= 1'b0;
            new_pc_o     <= 32'd0;
            excepttype_o <= 32'd0;
            exc_we_o     <= 1'b0;
            exc_epc_we_o <= 1'b0;
            exc_code_o   <= 5'd0;
            exc_epc_o    <= 32'd0;
            exc_bd_o     <= 1'b0;
            eret_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state        <= FLUSH;
                        flush_o      <= 1'b1;
                        excepttype_o <= sel_type;
                        if (exc_count_o != 16'hFFFF)
                            exc_count_o <= exc_count_o + 16'd1;
                        if (sel_eret) begin
                            new_pc_o <= epc_e;
                            eret_o   <= 1'b1;
                        end else begin
                            new_pc_o     <= 32'h0000_0020;
                            exc_we_o     <= 1'b1;
                            exc_epc_we_o <= ~status_e[1];
                            exc_code_o   <= sel_code;
                            exc_epc_o    <= epc_val;
                            exc_bd_o     <= in_delayslot_i;
                        end
                    end
                end
                FLUSH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
